// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex7 segment table and frame snapshot type for the scan driver.
package seg7_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   pt;
    logic [NUM_DIGITS-1:0]   le;
  } seg7_frame_t;
endpackage

// File: rtl/seg7_scan_drv_if.sv
// seg7_scan_drv_if: display word/masks from the multiplexer and the scanned display pins.
interface seg7_scan_drv_if;
  import seg7_pkg::*;
  logic [4*NUM_DIGITS-1:0] disp_num;
  logic [NUM_DIGITS-1:0]   point_in;
  logic [NUM_DIGITS-1:0]   le_in;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [7:0]              seg_n;
  logic                    frame_start;
  modport master(output disp_num, point_in, le_in, input an_n, seg_n, frame_start);
  modport slave(input disp_num, point_in, le_in, output an_n, seg_n, frame_start);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low g..a segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX7[nib];
endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: 8-digit multiplexed 7-segment scanner with per-frame input snapshot,
// blink and a blank gap at the start of every digit slot.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 2000,
  parameter int BLINK_LOG2 = 25
) (
  input logic           clk,
  input logic           rst,
  seg7_scan_drv_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0]         cnt;
  logic [2:0]            dig;
  logic [BLINK_LOG2-1:0] bc;
  seg7_frame_t           sh;
  logic [3:0]            nib;
  logic [6:0]            hex;
  logic                  wrap, snap, blank, bp;
  always_comb begin
    wrap  = cnt == CW'(SCAN_DIV - 1);
    snap  = cnt == '0 && dig == '0;
    blank = cnt < CW'(BLANK_CYC);
    bp    = bc[BLINK_LOG2-1];
    nib   = sh.num[{dig, 2'b00} +: 4];
  end
  seg7_hex_decode u_dec (.nib(nib), .seg(hex));
  // Snapshot lands while slot 0 is still blanked, so stale shadow data is never shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      dig             <= '0;
      bc              <= '0;
      sh              <= '0;
      bus.an_n        <= AN_OFF;
      bus.seg_n       <= SEG_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      cnt             <= wrap ? '0 : cnt + CW'(1);
      dig             <= wrap ? dig + 3'd1 : dig;
      bc              <= bc + BLINK_LOG2'(1);
      bus.frame_start <= snap;
      if (snap) sh <= '{num: bus.disp_num, pt: bus.point_in, le: bus.le_in};
      bus.an_n        <= blank ? AN_OFF : ~(8'h01 << dig);
      bus.seg_n       <= blank || (sh.le[dig] && bp) ? SEG_OFF : {~sh.pt[dig], hex};
    end
  end
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: directed frame-by-frame checks of the scan driver with SCAN_DIV=8,
// BLANK_CYC=2, BLINK_LOG2=6, plus a running anode-exclusivity/gap monitor.
module tb_seg7_scan_drv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic mon = 1'b0;
  logic [7:0] prev_an = 8'hFF;
  seg7_scan_drv_if bus ();
  seg7_scan_drv #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_LOG2(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // Starts on the sample where frame_start is high; ends on the next frame's frame_start.
  task automatic check_frame(input string tag, input logic [7:0] e [8], input int chg,
                             input logic [31:0] nd, input logic [7:0] np, input logic [7:0] nl);
    logic [7:0] an_exp, seg_exp;
    for (int j = 0; j < 64; j++) begin
      an_exp  = (j % 8 < 2) ? 8'hFF : ~(8'h01 << (j / 8));
      seg_exp = (j % 8 < 2) ? 8'hFF : e[j / 8];
      chk($sformatf("%s_an_j%0d", tag, j), {24'h0, bus.an_n}, {24'h0, an_exp});
      chk($sformatf("%s_seg_j%0d", tag, j), {24'h0, bus.seg_n}, {24'h0, seg_exp});
      chk($sformatf("%s_fs_j%0d", tag, j), {31'h0, bus.frame_start}, (j == 0) ? 32'd1 : 32'd0);
      if (j == chg) begin
        bus.disp_num = nd;
        bus.point_in = np;
        bus.le_in    = nl;
      end
      @(negedge clk);
    end
    chk($sformatf("%s_fs_next", tag), {31'h0, bus.frame_start}, 32'd1);
  endtask
  always @(negedge clk) begin
    if (mon) begin
      chk("one_anode", {31'h0, $countones(~bus.an_n) <= 1}, 32'd1);
      if (bus.an_n != 8'hFF && prev_an != 8'hFF) chk("blank_gap", {24'h0, bus.an_n}, {24'h0, prev_an});
      prev_an = bus.an_n;
    end
  end
  initial begin
    bus.disp_num = 32'h89AB_CDEF;
    bus.point_in = 8'h00;
    bus.le_in    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'h0, bus.an_n}, 32'hFF);
    chk("rst_seg", {24'h0, bus.seg_n}, 32'hFF);
    chk("rst_fs", {31'h0, bus.frame_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mon = 1'b1;
    check_frame("hex", '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}, 40, 32'h0, 8'h00, 8'h00);
    check_frame("coh_old", '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, 24, 32'h1111_1111, 8'h00, 8'h00);
    check_frame("coh_new", '{8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9}, 40, 32'h8888_8888, 8'h81, 8'h00);
    check_frame("dp", '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00}, 40, 32'h0, 8'h00, 8'h44);
    check_frame("blink", '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hC0}, 40, 32'h89AB_CDEF, 8'h00, 8'h00);
    check_frame("hex2", '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}, -1, 32'h0, 8'h00, 8'h00);
    repeat (43) @(negedge clk);
    chk("pre_rst_an", {24'h0, bus.an_n}, 32'hDF);
    mon = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_an", {24'h0, bus.an_n}, 32'hFF);
    chk("async_seg", {24'h0, bus.seg_n}, 32'hFF);
    chk("async_fs", {31'h0, bus.frame_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    prev_an = 8'hFF;
    mon = 1'b1;
    check_frame("post_rst", '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}, -1, 32'h0, 8'h00, 8'h00);
    mon = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
